// File: rtl/traffic_light_controller_if.sv
// Board-side signal bundle for the four-way traffic-light sequencer.
// The host (master) drives the button and the current light status.
// The controller (slave) returns the registered next state and the decoded lamp/display outputs.
interface traffic_light_controller_if;
  logic        btn;
  logic [15:0] input_ligth_status;
  logic [15:0] output_ligth_status;
  logic [2:0]  n_lights;
  logic [2:0]  s_lights;
  logic [2:0]  e_lights;
  logic [2:0]  w_lights;
  logic [6:0]  segment;
  logic        an;

  modport master (
    output btn,
    output input_ligth_status,
    input  output_ligth_status,
    input  n_lights,
    input  s_lights,
    input  e_lights,
    input  w_lights,
    input  segment,
    input  an
  );

  modport slave (
    input  btn,
    input  input_ligth_status,
    output output_ligth_status,
    output n_lights,
    output s_lights,
    output e_lights,
    output w_lights,
    output segment,
    output an
  );
endinterface

// File: rtl/traffic_light_controller.sv
// Four-way traffic-light sequencer.
// Each edge registers the successor of the externally supplied light state:
//   - btn forces all-red;
//   - otherwise the eight-phase N/S/E/W green-yellow rotation advances;
//   - anything off the rotation restarts at north green.
// Lamps and a one-digit active-low phase display are decoded from the registered state.
module traffic_light_controller (
  input  logic                        clk,
  input  logic                        rst_n,
  traffic_light_controller_if.slave   bus
);

  typedef enum logic [15:0] {
    ST_N_GREEN  = 16'h1444,
    ST_N_YELLOW = 16'h2444,
    ST_S_GREEN  = 16'h4144,
    ST_S_YELLOW = 16'h4244,
    ST_E_GREEN  = 16'h4414,
    ST_E_YELLOW = 16'h4424,
    ST_W_GREEN  = 16'h4441,
    ST_W_YELLOW = 16'h4442,
    ST_ALL_RED  = 16'h4444
  } light_state_e;

  light_state_e status_q;
  light_state_e status_d;
  logic [6:0]   segment_d;

  // Next-state function: the all-stop request wins, then the rotation table.
  // All-red and every unrecognised pattern fall back to north green.
  always_comb begin
    status_d = ST_N_GREEN;
    if (bus.btn) begin
      status_d = ST_ALL_RED;
    end else begin
      case (bus.input_ligth_status)
        ST_N_GREEN:  status_d = ST_N_YELLOW;
        ST_N_YELLOW: status_d = ST_S_GREEN;
        ST_S_GREEN:  status_d = ST_S_YELLOW;
        ST_S_YELLOW: status_d = ST_E_GREEN;
        ST_E_GREEN:  status_d = ST_E_YELLOW;
        ST_E_YELLOW: status_d = ST_W_GREEN;
        ST_W_GREEN:  status_d = ST_W_YELLOW;
        ST_W_YELLOW: status_d = ST_N_GREEN;
        default:     status_d = ST_N_GREEN;
      endcase
    end
  end

  // State register; reset parks the junction at all-red.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= ST_ALL_RED;
    end else begin
      status_q <= status_d;
    end
  end

  // Phase digit display, active-low gfedcba. All-red and unknown states show 0.
  always_comb begin
    segment_d = 7'h40;
    case (status_q)
      ST_N_GREEN:  segment_d = 7'h79;
      ST_N_YELLOW: segment_d = 7'h24;
      ST_S_GREEN:  segment_d = 7'h30;
      ST_S_YELLOW: segment_d = 7'h19;
      ST_E_GREEN:  segment_d = 7'h12;
      ST_E_YELLOW: segment_d = 7'h02;
      ST_W_GREEN:  segment_d = 7'h78;
      ST_W_YELLOW: segment_d = 7'h00;
      default:     segment_d = 7'h40;
    endcase
  end

  assign bus.output_ligth_status = status_q;
  assign bus.n_lights            = status_q[14:12];
  assign bus.s_lights            = status_q[10:8];
  assign bus.e_lights            = status_q[6:4];
  assign bus.w_lights            = status_q[2:0];
  assign bus.segment             = segment_d;
  assign bus.an                  = 1'b0;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Self-checking bench for traffic_light_controller.
// Each driven transaction pushes its expected state into a queue.
// The state is popped and compared one edge later.
module tb_traffic_light_controller;

  logic clk;
  logic rst_n;
  int   chk_cnt;
  int   pass_cnt;
  logic [15:0] exp_q[$];

  traffic_light_controller_if bus_if ();

  traffic_light_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent expectation of the phase display for a given light state.
  function automatic logic [6:0] seg_of(input logic [15:0] st);
    case (st)
      16'h1444: return 7'h79;
      16'h2444: return 7'h24;
      16'h4144: return 7'h30;
      16'h4244: return 7'h19;
      16'h4414: return 7'h12;
      16'h4424: return 7'h02;
      16'h4441: return 7'h78;
      16'h4442: return 7'h00;
      default:  return 7'h40;
    endcase
  endfunction

  // Drive one transaction on the falling edge and record its expected result.
  task automatic drive(input logic b, input logic [15:0] in_st, input logic [15:0] exp_st);
    @(negedge clk);
    bus_if.btn                = b;
    bus_if.input_ligth_status = in_st;
    exp_q.push_back(exp_st);
  endtask

  // Advance one edge, pop the expected state and compare status and display.
  task automatic edge_and_check(input string name);
    logic [15:0] exp_st;
    @(posedge clk);
    #1;
    chk_cnt++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty, actual status %h", name, bus_if.output_ligth_status);
      return;
    end
    exp_st = exp_q.pop_front();
    if (bus_if.output_ligth_status !== exp_st)
      $display("FAIL %s: status actual %h required %h", name, bus_if.output_ligth_status, exp_st);
    else
      pass_cnt++;
    chk_cnt++;
    if (bus_if.segment !== seg_of(exp_st))
      $display("FAIL %s: segment actual %h required %h", name, bus_if.segment, seg_of(exp_st));
    else
      pass_cnt++;
    $display("%s: btn=%b in=%h out=%h seg=%h", name, bus_if.btn, bus_if.input_ligth_status,
             bus_if.output_ligth_status, bus_if.segment);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus_if.btn = 1'b0;
    bus_if.input_ligth_status = 16'h1444;
    #12;
    chk_cnt++;
    if (bus_if.output_ligth_status !== 16'h4444)
      $display("FAIL reset_status: actual %h required 4444", bus_if.output_ligth_status);
    else pass_cnt++;
    chk_cnt++;
    if ({bus_if.n_lights, bus_if.s_lights, bus_if.e_lights, bus_if.w_lights} !== 12'b100100100100)
      $display("FAIL reset_lamps: actual %b required 100100100100",
               {bus_if.n_lights, bus_if.s_lights, bus_if.e_lights, bus_if.w_lights});
    else pass_cnt++;
    chk_cnt++;
    if (bus_if.segment !== 7'h40 || bus_if.an !== 1'b0)
      $display("FAIL reset_display: actual seg %h an %b required 40 0", bus_if.segment, bus_if.an);
    else pass_cnt++;
    $display("reset: out=%h seg=%h", bus_if.output_ligth_status, bus_if.segment);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 16'h4444, 16'h1444);
    edge_and_check("reset_release");
    chk_cnt++;
    if (bus_if.n_lights !== 3'b001)
      $display("FAIL release_n_lights: actual %b required 001", bus_if.n_lights);
    else pass_cnt++;
  endtask

  task automatic test_rotation;
    logic [15:0] ins  [8] = '{16'h1444, 16'h2444, 16'h4144, 16'h4244,
                              16'h4414, 16'h4424, 16'h4441, 16'h4442};
    logic [15:0] exps [8] = '{16'h2444, 16'h4144, 16'h4244, 16'h4414,
                              16'h4424, 16'h4441, 16'h4442, 16'h1444};
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, ins[i], exps[i]);
      edge_and_check("rotation");
    end
  endtask

  task automatic test_all_stop;
    logic [15:0] ins [3] = '{16'h1444, 16'h4424, 16'h4444};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ins[i], 16'h4444);
      edge_and_check("all_stop");
    end
    drive(1'b0, 16'h4444, 16'h1444);
    edge_and_check("all_stop_resume");
  endtask

  task automatic test_illegal;
    logic [15:0] ins [3] = '{16'h0000, 16'h1144, 16'h4448};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, ins[i], 16'h1444);
      edge_and_check("illegal");
    end
  endtask

  task automatic test_async_reset;
    drive(1'b0, 16'h4144, 16'h4244);
    edge_and_check("async_setup");
    #2;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (bus_if.output_ligth_status !== 16'h4444)
      $display("FAIL async_reset: actual %h required 4444", bus_if.output_ligth_status);
    else pass_cnt++;
    $display("async_reset: out=%h", bus_if.output_ligth_status);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 16'h4444, 16'h1444);
    edge_and_check("async_release");
  endtask

  task automatic test_lamps;
    drive(1'b0, 16'h4414, 16'h4424);
    edge_and_check("lamps");
    chk_cnt++;
    if ({bus_if.n_lights, bus_if.s_lights, bus_if.e_lights, bus_if.w_lights} !== 12'b100100010100)
      $display("FAIL lamps_slices: actual %b required 100100010100",
               {bus_if.n_lights, bus_if.s_lights, bus_if.e_lights, bus_if.w_lights});
    else pass_cnt++;
    chk_cnt++;
    if (bus_if.an !== 1'b0)
      $display("FAIL lamps_an: actual %b required 0", bus_if.an);
    else pass_cnt++;
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    test_reset();
    test_rotation();
    test_all_stop();
    test_illegal();
    test_async_reset();
    test_lamps();
    chk_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_drain: actual %0d left required 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/traffic_light_controller.md
Name: traffic_light_controller

Overview:
Four-way intersection traffic-light sequencer (north, south, east, west).
- Each rising clock edge, it computes the next light state from a 16-bit packed current-state input and a button input, and registers the result.
- The registered state drives the packed status output, per-direction 3-bit lamp outputs, and a single-digit 7-segment phase display.
- It sits between board I/O (button, lamps, display) and a test or host that feeds the current light status.

Parameters:
none

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
btn  input  1  all-stop request; 1 forces all-red, 0 lets the phase advance
input_ligth_status  input  16  packed current light state: [15:12]=N, [11:8]=S, [7:4]=E, [3:0]=W
output_ligth_status  output  16  registered next light state, same packing
n_lights  output  3  north lamp = output_ligth_status[14:12]
s_lights  output  3  south lamp = output_ligth_status[10:8]
e_lights  output  3  east lamp = output_ligth_status[6:4]
w_lights  output  3  west lamp = output_ligth_status[2:0]
segment  output  7  active-low 7-segment pattern, bit order gfedcba (bit6=g)
an  output  1  active-low digit anode enable

Behaviour:
- Nibble light codes:
  - 4'h1 = green
  - 4'h2 = yellow
  - 4'h4 = red
  - Other codes are illegal.
- Reset (rst_n=0, asynchronous):
  - output_ligth_status = 16'h4444 (all red).
  - Lamps = 3'b100 each.
  - segment shows digit 0 (7'h40).
  - an = 0.
  - Held while rst_n is low.
  - Release takes effect on the first rising clk edge with rst_n=1.
- Next-state function, latched into output_ligth_status on each rising clk edge (1-cycle latency, no handshake):
  - btn=1: next = 16'h4444, for any input.
  - btn=0, 8-phase rotation:
    - 1444 -> 2444 (N green -> N yellow)
    - 2444 -> 4144 (N yellow -> S green)
    - 4144 -> 4244 (S green -> S yellow)
    - 4244 -> 4414 (S yellow -> E green)
    - 4414 -> 4424 (E green -> E yellow)
    - 4424 -> 4441 (E yellow -> W green)
    - 4441 -> 4442 (W green -> W yellow)
    - 4442 -> 1444 (W yellow -> N green, wrap-around)
  - btn=0, input 4444 (all red): next = 1444 (restart at N green).
  - btn=0, any other input (including 0000, two greens, illegal codes): next = 1444 (resynchronise).
- Output stability: output_ligth_status never equals 4444 when btn=0 was sampled on the last edge.
- Lamp outputs: combinational slices of the registered state (bit0 green, bit1 yellow, bit2 red).
- Display: segment is combinational from the registered state.
  - Phase digit: 1444=1, 2444=2, 4144=3, 4244=4, 4414=5, 4424=6, 4441=7, 4442=8, anything else=0.
  - Active-low encodings:
    - 0=7'h40
    - 1=7'h79
    - 2=7'h24
    - 3=7'h30
    - 4=7'h19
    - 5=7'h12
    - 6=7'h02
    - 7=7'h78
    - 8=7'h00
  - an is tied 0.
- Simultaneous events:
  - rst_n low overrides everything.
  - btn=1 overrides the table.
  - Asserting reset mid-sequence returns to 4444 immediately; the next edge after release with btn=0 goes to 1444.

Test Plan:
1. Reset: rst_n=0 -> output 4444, lamps 100/100/100/100, segment 7'h40, an=0; release, input 4444, btn=0, one edge -> 1444, n_lights=001, segment 7'h79.
2. Full rotation: btn=0, feed each of the 8 table inputs one per edge -> 2444, 4144, 4244, 4414, 4424, 4441, 4442, 1444, with segment digits 2..8, 1.
3. All-stop: btn=1 with inputs 1444, 4424 and 4444 -> 4444 each edge; then btn=0 with input 4444 -> 1444.
4. Illegal input: btn=0 with inputs 0000, 1144, 4448 -> 1444 each.
5. Async reset mid-phase: output at 4244, drop rst_n between edges -> output 4444 without a clock edge.
6. Lamp/packing check: output 4424 -> e_lights=010, others 100, segment 7'h02.
